// File: rtl/relu_stream_ctrl_if.sv
// Streaming ReLU controller bus: feature-buffer read port, activated output stream, status.
// Latency: none, signal bundle only.
// Backpressure: out_ready from the consumer; the controller throttles rd_en against it.
//
// Signals
//   start      single-cycle request to process one tensor
//   busy       high from accepted start until done
//   done       one-cycle pulse after the final element handshake
//   rd_en      feature-buffer read strobe
//   rd_addr    feature-buffer read address
//   rd_data    signed read data, valid one cycle after rd_en
//   out_data   signed activated element
//   out_valid  out_data valid
//   out_ready  downstream accepts
//   out_last   final element of the tensor
//   neg_count  elements clamped because they were negative
// Modports: master = controller side, slave = host/buffer/consumer side.
interface relu_stream_ctrl_if #(
    parameter int ADDR_W  = 8,
    parameter int BIT_REP = 8
);
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_addr;
    logic signed [BIT_REP-1:0] rd_data;
    logic signed [BIT_REP-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic [ADDR_W:0]           neg_count;

    modport master (
        input  start, rd_data, out_ready,
        output busy, done, rd_en, rd_addr, out_data, out_valid, out_last, neg_count
    );

    modport slave (
        output start, rd_data, out_ready,
        input  busy, done, rd_en, rd_addr, out_data, out_valid, out_last, neg_count
    );
endinterface

// File: rtl/relu_stream_ctrl.sv
// Reads one IN_WIDTH x IN_LENGTH x IN_DEPTH tensor linearly from a feature buffer, applies ReLU, streams it out.
// Latency: first rd_en one cycle after start; first out_valid two cycles after first rd_en; one element/cycle.
// Backpressure: out_ready stalls the 2-entry output FIFO; rd_en is throttled so the FIFO never overflows.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   bus          relu_stream_ctrl_if master modport (start/busy/done, read port, output stream, neg_count)
//
// Also contains relu_stream_fifo, the small generic FIFO used for the output buffer.

// Generic synchronous FIFO with occupancy output.
// Latency: one cycle from push to head visible.
// Backpressure: push is ignored when full; caller is expected to throttle using count.
module relu_stream_fifo #(
    parameter  int W     = 9,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push_ok;
    logic          pop_ok;

    assign pop_ok   = pop && (cnt != '0);
    assign push_ok  = push_vld && (cnt != CW'(DEPTH));
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;
    assign empty    = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module relu_stream_ctrl #(
    parameter int IN_WIDTH  = 8,
    parameter int IN_LENGTH = 8,
    parameter int IN_DEPTH  = 4,
    parameter int BIT_REP   = 8,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    relu_stream_ctrl_if.master bus
);
    localparam int N = IN_WIDTH * IN_LENGTH * IN_DEPTH;
    localparam logic [ADDR_W-1:0]         LAST_ADDR = ADDR_W'(N - 1);
    localparam logic signed [BIT_REP-1:0] ZERO      = '0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state;
    logic [ADDR_W-1:0]         rd_addr_q;
    logic [ADDR_W-1:0]         ret_cnt;     // elements returned so far this tensor
    logic                      rd_vld_d;    // rd_data is valid this cycle
    logic                      done_q;
    logic [ADDR_W:0]           neg_cnt;

    logic signed [BIT_REP-1:0] rd_dat;
    logic signed [BIT_REP-1:0] relu_val;
    logic                      push_last;
    logic [BIT_REP:0]          head;
    logic [1:0]                fifo_cnt;
    logic                      fifo_empty;
    logic                      pop;
    logic                      head_last;
    logic                      start_acc;
    logic                      rd_go;

    assign rd_dat    = bus.rd_data;
    assign start_acc = bus.start && (state == IDLE);
    assign pop       = !fifo_empty && bus.out_ready;
    assign head_last = head[BIT_REP];

    // Issue a read only if everything already stored or returning, minus this
    // cycle's pop, leaves room for it. Evaluated combinationally so the pop of
    // the current cycle can be credited, which is what sustains one element per
    // cycle through a 2-entry FIFO.
    assign rd_go = (state == RUN) &&
                   ((3'(fifo_cnt) + 3'(rd_vld_d)) < (3'd2 + 3'(pop)));

    assign relu_val  = (rd_dat > ZERO) ? rd_dat : ZERO;
    assign push_last = (ret_cnt == LAST_ADDR);

    relu_stream_fifo #(
        .W     (BIT_REP + 1),
        .DEPTH (2)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rd_vld_d),
        .push_dat ({push_last, relu_val}),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_cnt),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_addr_q <= '0;
            ret_cnt   <= '0;
            rd_vld_d  <= 1'b0;
            done_q    <= 1'b0;
            neg_cnt   <= '0;
        end else begin
            rd_vld_d <= rd_go;
            done_q   <= (state == DRAIN) && pop && head_last;

            case (state)
                IDLE: begin
                    if (start_acc) begin
                        state     <= RUN;
                        rd_addr_q <= '0;
                    end
                end
                RUN: begin
                    if (rd_go) begin
                        if (rd_addr_q == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (start_acc) begin
                ret_cnt <= '0;
                neg_cnt <= '0;
            end else if (rd_vld_d) begin
                ret_cnt <= ret_cnt + 1'b1;
                if (rd_dat < ZERO) begin
                    neg_cnt <= neg_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_go;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_data  = head[BIT_REP-1:0];
    assign bus.out_valid = !fifo_empty;
    assign bus.out_last  = head_last;
    assign bus.neg_count = neg_cnt;
endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Directed bench for relu_stream_ctrl: a 2x2x1 instance and a default-size instance.
// Cycle t is the interval after rising edge t; inputs driven 1 time unit after the edge,
// outputs sampled 2 time units after the edge.
module tb_relu_stream_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    relu_stream_ctrl_if #(.ADDR_W(8), .BIT_REP(8)) bs ();
    relu_stream_ctrl_if #(.ADDR_W(8), .BIT_REP(8)) bb ();

    relu_stream_ctrl #(
        .IN_WIDTH(2), .IN_LENGTH(2), .IN_DEPTH(1), .BIT_REP(8), .ADDR_W(8)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs)
    );

    relu_stream_ctrl dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bb)
    );

    // Feature buffers: one-cycle read latency.
    logic [7:0] smem [4];
    always @(posedge clk) begin
        if (bs.rd_en) bs.rd_data <= smem[bs.rd_addr[1:0]];
    end
    always @(posedge clk) begin
        bb.rd_data <= 8'sd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sstep(input logic st, input logic rdy);
        tick();
        bs.start     = st;
        bs.out_ready = rdy;
    endtask

    // Per-cycle check of the small instance; address/data/last only checked where meaningful.
    task automatic cyc(input string tag, input logic e_rd, input int e_addr, input logic e_vld,
                       input int e_dat, input logic e_last, input logic e_done, input logic e_busy);
        #1;
        chk({tag, "/rd_en"}, 32'(bs.rd_en), 32'(e_rd));
        if (e_rd) chk({tag, "/rd_addr"}, 32'(bs.rd_addr), e_addr);
        chk({tag, "/out_valid"}, 32'(bs.out_valid), 32'(e_vld));
        if (e_vld) begin
            chk({tag, "/out_data"}, 32'(bs.out_data), e_dat);
            chk({tag, "/out_last"}, 32'(bs.out_last), 32'(e_last));
        end
        chk({tag, "/done"}, 32'(bs.done), 32'(e_done));
        chk({tag, "/busy"}, 32'(bs.busy), 32'(e_busy));
    endtask

    // 4-element run with out_ready high; optional second start while busy.
    task automatic run_basic(input string tag, input logic restart);
        sstep(1, 1); cyc({tag, "/c0"}, 0, 0, 0, 0, 0, 0, 0);
        sstep(0, 1); cyc({tag, "/c1"}, 1, 0, 0, 0, 0, 0, 1);
        sstep(restart, 1); cyc({tag, "/c2"}, 1, 1, 0, 0, 0, 0, 1);
        sstep(0, 1); cyc({tag, "/c3"}, 1, 2, 1, 5, 0, 0, 1);
        sstep(0, 1); cyc({tag, "/c4"}, 1, 3, 1, 0, 0, 0, 1);
        sstep(0, 1); cyc({tag, "/c5"}, 0, 0, 1, 0, 0, 0, 1);
        sstep(0, 1); cyc({tag, "/c6"}, 0, 0, 1, 0, 1, 0, 1);
        sstep(0, 1); cyc({tag, "/c7"}, 0, 0, 0, 0, 0, 1, 0);
        chk({tag, "/neg_count"}, 32'(bs.neg_count), 2);
        sstep(0, 1); cyc({tag, "/c8"}, 0, 0, 0, 0, 0, 0, 0);
        sstep(0, 1); cyc({tag, "/c9"}, 0, 0, 0, 0, 0, 0, 0);
        chk({tag, "/neg_hold"}, 32'(bs.neg_count), 2);
    endtask

    initial begin
        int hs, first_hs, last_hs, last_rd, done_c, last_idx, last_cnt, bad_dat;

        smem[0] = 8'd5;
        smem[1] = 8'hFD;   // -3
        smem[2] = 8'd0;
        smem[3] = 8'h80;   // -128
        bs.start = 0; bs.out_ready = 1;
        bb.start = 0; bb.out_ready = 1;

        // Reset state
        repeat (3) tick();
        #1;
        chk("rst/busy", 32'(bs.busy), 0);
        chk("rst/done", 32'(bs.done), 0);
        chk("rst/rd_en", 32'(bs.rd_en), 0);
        chk("rst/rd_addr", 32'(bs.rd_addr), 0);
        chk("rst/out_valid", 32'(bs.out_valid), 0);
        chk("rst/out_last", 32'(bs.out_last), 0);
        chk("rst/out_data", 32'(bs.out_data), 0);
        chk("rst/neg_count", 32'(bs.neg_count), 0);
        chk("rst/big_valid", 32'(bb.out_valid), 0);
        tick();
        rst_n = 1;
        repeat (2) tick();

        run_basic("basic", 0);
        run_basic("restart", 1);

        // Output stalled in cycles 3-7
        sstep(1, 1); cyc("stall/c0", 0, 0, 0, 0, 0, 0, 0);
        sstep(0, 1); cyc("stall/c1", 1, 0, 0, 0, 0, 0, 1);
        sstep(0, 1); cyc("stall/c2", 1, 1, 0, 0, 0, 0, 1);
        sstep(0, 0); cyc("stall/c3", 0, 0, 1, 5, 0, 0, 1);
        sstep(0, 0); cyc("stall/c4", 0, 0, 1, 5, 0, 0, 1);
        sstep(0, 0); cyc("stall/c5", 0, 0, 1, 5, 0, 0, 1);
        sstep(0, 0); cyc("stall/c6", 0, 0, 1, 5, 0, 0, 1);
        sstep(0, 0); cyc("stall/c7", 0, 0, 1, 5, 0, 0, 1);
        sstep(0, 1); cyc("stall/c8", 1, 2, 1, 5, 0, 0, 1);
        sstep(0, 1); cyc("stall/c9", 1, 3, 1, 0, 0, 0, 1);
        sstep(0, 1); cyc("stall/c10", 0, 0, 1, 0, 0, 0, 1);
        sstep(0, 1); cyc("stall/c11", 0, 0, 1, 0, 1, 0, 1);
        sstep(0, 1); cyc("stall/c12", 0, 0, 0, 0, 0, 1, 0);
        chk("stall/neg_count", 32'(bs.neg_count), 2);
        repeat (2) sstep(0, 1);

        // Reset mid-tensor at cycle 3
        sstep(1, 1); cyc("mrst/c0", 0, 0, 0, 0, 0, 0, 0);
        sstep(0, 1); cyc("mrst/c1", 1, 0, 0, 0, 0, 0, 1);
        sstep(0, 1); cyc("mrst/c2", 1, 1, 0, 0, 0, 0, 1);
        tick();
        rst_n = 0;
        #1;
        chk("mrst/busy", 32'(bs.busy), 0);
        chk("mrst/done", 32'(bs.done), 0);
        chk("mrst/rd_en", 32'(bs.rd_en), 0);
        chk("mrst/out_valid", 32'(bs.out_valid), 0);
        chk("mrst/out_last", 32'(bs.out_last), 0);
        chk("mrst/out_data", 32'(bs.out_data), 0);
        chk("mrst/neg_count", 32'(bs.neg_count), 0);
        tick();
        rst_n = 1;
        cyc("mrst/c4", 0, 0, 0, 0, 0, 0, 0);
        sstep(0, 1); cyc("mrst/c5", 0, 0, 0, 0, 0, 0, 0);
        sstep(0, 1); cyc("mrst/c6", 0, 0, 0, 0, 0, 0, 0);
        sstep(0, 1); cyc("mrst/c7", 0, 0, 0, 0, 0, 0, 0);
        chk("mrst/neg_after", 32'(bs.neg_count), 0);
        run_basic("fresh", 0);

        // Default-size tensor, 256 elements at full rate
        hs = 0; first_hs = -1; last_hs = -1; last_rd = -1; done_c = -1;
        last_idx = -1; last_cnt = 0; bad_dat = 0;
        for (int c = 0; c < 320; c++) begin
            tick();
            bb.start = (c == 0);
            #1;
            if (bb.rd_en) last_rd = c;
            if (bb.out_valid && bb.out_ready) begin
                hs++;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                if (bb.out_data !== 8'sd1) bad_dat++;
                if (bb.out_last) begin
                    last_cnt++;
                    last_idx = hs;
                end
            end
            if (bb.done) begin
                done_c = c;
                break;
            end
        end
        bb.start = 0;
        chk("big/handshakes", hs, 256);
        chk("big/first_hs", first_hs, 3);
        chk("big/no_bubble", last_hs - first_hs, 255);
        chk("big/last_rd", last_rd, 256);
        chk("big/done_gap", done_c - last_rd, 3);
        chk("big/data", bad_dat, 0);
        chk("big/last_idx", last_idx, 256);
        chk("big/last_cnt", last_cnt, 1);
        chk("big/neg_count", 32'(bb.neg_count), 0);
        chk("big/busy_at_done", 32'(bb.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
